// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared widths and shifter state encoding for serial_stream_tx
package serial_tx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } tx_state_e;

   // Counter width that never collapses to zero bits for a modulus of 1.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int level_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with wrap-bit pointers
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_n_i,
   input  logic                             wr_en_i,
   input  logic [WIDTH-1:0]                 wr_data_i,
   input  logic                             rd_en_i,
   output logic [WIDTH-1:0]                 rd_data_o,
   output logic                             full_o,
   output logic                             empty_o,
   output logic [$clog2(DEPTH+1)-1:0]       level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             push;
   logic             pop;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o   = wr_ptr_q - rd_ptr_q;
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   // A full FIFO refuses writes even when a read frees a slot in the same cycle.
   assign push = wr_en_i && !full_o;
   assign pop  = rd_en_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/serial_stream_tx.sv
// rtl/serial_stream_tx.sv - multi-lane source-synchronous serial transmitter with frame sync
module serial_stream_tx
   import serial_tx_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int LANES       = 1,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_PERIOD = 4,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [LANES*DATA_W-1:0]              in_data,
   output logic [LANES-1:0]                     ser_data,
   output logic                                 clk_en,
   output logic                                 sync_out,
   output logic                                 busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);
   localparam int BW = cnt_w(DATA_W);
   localparam int WW = cnt_w(SYNC_PERIOD);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(SYNC_PERIOD - 1);

   tx_state_e               state_q;
   logic [BW-1:0]           bit_cnt_q;
   logic [WW-1:0]           word_cnt_q;
   logic [DATA_W-1:0]       shreg_q [LANES];
   logic [LANES-1:0]        ser_q;
   logic                    clk_en_q;
   logic                    sync_q;
   logic                    rdy_en_q;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_wr;
   logic                    last_bit;
   logic                    pop;
   logic [LANES*DATA_W-1:0] fifo_rdata;

   assign in_ready = rdy_en_q && !fifo_full;
   assign fifo_wr  = in_valid && in_ready;
   assign last_bit = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST);
   // Reloading on the last bit keeps consecutive words gap-free on the wire.
   assign pop      = !fifo_empty && ((state_q == IDLE) || last_bit);

   assign ser_data = ser_q;
   assign clk_en   = clk_en_q;
   assign sync_out = sync_q;
   assign busy     = !fifo_empty || (state_q == SHIFT) || clk_en_q;

   sync_fifo #(
      .WIDTH(LANES*DATA_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .wr_en_i  (fifo_wr),
      .wr_data_i(in_data),
      .rd_en_i  (pop),
      .rd_data_o(fifo_rdata),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .level_o  (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         ser_q      <= '0;
         clk_en_q   <= 1'b0;
         sync_q     <= 1'b0;
         rdy_en_q   <= 1'b0;
         for (int l = 0; l < LANES; l++) shreg_q[l] <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         sync_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               ser_q    <= '0;
               clk_en_q <= 1'b0;
               if (pop) state_q <= SHIFT;
            end
            SHIFT: begin
               clk_en_q <= 1'b1;
               for (int l = 0; l < LANES; l++)
                  ser_q[l] <= MSB_FIRST ? shreg_q[l][DATA_W-1] : shreg_q[l][0];
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_q  <= '0;
                  sync_q     <= (word_cnt_q == WORD_LAST);
                  word_cnt_q <= (word_cnt_q == WORD_LAST) ? '0 : word_cnt_q + WW'(1);
                  if (!pop) state_q <= IDLE;
               end else begin
                  bit_cnt_q <= bit_cnt_q + BW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
         for (int l = 0; l < LANES; l++) begin
            if (pop)
               shreg_q[l] <= fifo_rdata[l*DATA_W +: DATA_W];
            else if (state_q == SHIFT)
               shreg_q[l] <= MSB_FIRST ? {shreg_q[l][DATA_W-2:0], 1'b0}
                                       : {1'b0, shreg_q[l][DATA_W-1:1]};
         end
      end
   end

endmodule
